// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, control bit indices, stall FSM encoding and bubble constants
package mips_pkg;

  localparam int LEN_W        = 32;
  localparam int NB_ADDR_W    = 5;
  localparam int NB_CTRL_EX_W = 6;
  localparam int NB_CTRL_M_W  = 9;
  localparam int NB_CTRL_WB_W = 2;

  // Bit positions inside the MEM control bus
  localparam int MEM_WRITE_BIT = 0;
  localparam int MEM_READ_BIT  = 1;
  localparam int BRANCH_BIT    = 2;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } stall_state_t;

  localparam logic [NB_CTRL_EX_W-1:0] BUBBLE_EX  = '0;
  localparam logic [NB_CTRL_M_W-1:0]  BUBBLE_M   = '0;
  localparam logic [NB_CTRL_WB_W-1:0] BUBBLE_WB  = '0;

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 2-read/1-write register file, r0 hardwired to zero, write-first bypass
module regfile_bypass
  import mips_pkg::*;
#(
  parameter int LEN     = LEN_W,
  parameter int NB_ADDR = NB_ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [NB_ADDR-1:0] waddr,
  input  logic [LEN-1:0]     wdata,
  input  logic [NB_ADDR-1:0] raddr_a,
  input  logic [NB_ADDR-1:0] raddr_b,
  output logic [LEN-1:0]     rdata_a,
  output logic [LEN-1:0]     rdata_b
);

  localparam int NREG = 2 ** NB_ADDR;

  logic [LEN-1:0] regs [NREG];

  // Storage: cleared on reset, writes to r0 dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Read ports: r0 reads zero, same-cycle write is returned directly
  always_comb begin
    rdata_a = regs[raddr_a];
    rdata_b = regs[raddr_b];
    if (raddr_a == '0)                   rdata_a = '0;
    else if (we && (waddr == raddr_a))   rdata_a = wdata;
    if (raddr_b == '0)                   rdata_b = '0;
    else if (we && (waddr == raddr_b))   rdata_b = wdata;
  end

endmodule

// File: rtl/seg_decode_hazard.sv
// rtl/seg_decode_hazard.sv - ID stage: register file, ID branch resolution, stall control, ID/EX register
module seg_decode_hazard
  import mips_pkg::*;
#(
  parameter int LEN            = LEN_W,
  parameter int NB_ADDR        = NB_ADDR_W,
  parameter int NB_CTRL_EX     = NB_CTRL_EX_W,
  parameter int NB_CTRL_M      = NB_CTRL_M_W,
  parameter int NB_CTRL_WB     = NB_CTRL_WB_W,
  parameter int LOAD_USE_STALL = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [LEN-1:0]        i_PC,
  input  logic [LEN-1:0]        i_instruction,
  input  logic [NB_CTRL_EX-1:0] i_ctrl_exc,
  input  logic [NB_CTRL_M-1:0]  i_ctrl_mem,
  input  logic [NB_CTRL_WB-1:0] i_ctrl_wb,
  input  logic                  i_branch,
  input  logic                  i_bneq,
  input  logic                  i_flush,
  input  logic [NB_ADDR-1:0]    i_ex_rd,
  input  logic                  i_ex_RegWrite,
  input  logic                  i_ex_MemRead,
  input  logic [NB_ADDR-1:0]    i_mem_rd,
  input  logic                  i_mem_RegWrite,
  input  logic                  i_mem_MemRead,
  input  logic [LEN-1:0]        i_mem_result,
  input  logic [NB_ADDR-1:0]    i_wb_rd,
  input  logic                  i_wb_RegWrite,
  input  logic [LEN-1:0]        i_wb_data,
  output logic                  o_stall,
  output logic                  o_branch_taken,
  output logic [LEN-1:0]        o_branch_target,
  output logic                  o_valid,
  output logic [LEN-1:0]        o_PC,
  output logic [LEN-1:0]        o_rs_data,
  output logic [LEN-1:0]        o_rt_data,
  output logic [LEN-1:0]        o_imm,
  output logic [NB_ADDR-1:0]    o_rs,
  output logic [NB_ADDR-1:0]    o_rt,
  output logic [NB_ADDR-1:0]    o_rd,
  output logic [NB_CTRL_EX-1:0] o_ctrl_exc,
  output logic [NB_CTRL_M-1:0]  o_ctrl_mem,
  output logic [NB_CTRL_WB-1:0] o_ctrl_wb
);

  // Remaining HOLD cycles after the first load-use stall cycle
  localparam logic [1:0] LU_CNT = 2'(LOAD_USE_STALL - 1);

  stall_state_t       state;
  logic [1:0]         cnt;

  logic [NB_ADDR-1:0] rs, rt, rd;
  logic [LEN-1:0]     imm;
  logic [LEN-1:0]     rf_rs, rf_rt;
  logic [LEN-1:0]     cmp_rs, cmp_rt;
  logic               id_valid;
  logic               load_use, br_ex, br_mem;
  logic               bubble;
  logic               unused_opcode;

  assign rs  = i_instruction[21 +: NB_ADDR];
  assign rt  = i_instruction[16 +: NB_ADDR];
  assign rd  = i_instruction[11 +: NB_ADDR];
  assign imm = {{(LEN-16){i_instruction[15]}}, i_instruction[15:0]};
  assign unused_opcode = ^i_instruction[31:26];

  regfile_bypass #(
    .LEN     (LEN),
    .NB_ADDR (NB_ADDR)
  ) u_regfile (
    .clk     (i_clk),
    .rst     (i_rst),
    .we      (i_wb_RegWrite),
    .waddr   (i_wb_rd),
    .wdata   (i_wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_rs),
    .rdata_b (rf_rt)
  );

  // Nonzero destination matching either source register
  function automatic logic src_hit(input logic [NB_ADDR-1:0] dst,
                                   input logic [NB_ADDR-1:0] s,
                                   input logic [NB_ADDR-1:0] t);
    return (dst != '0) && ((dst == s) || (dst == t));
  endfunction

  assign id_valid = i_valid & ~i_flush;
  assign load_use = id_valid & i_ex_MemRead & src_hit(i_ex_rd, rs, rt);
  assign br_ex    = id_valid & i_branch & i_ex_RegWrite & src_hit(i_ex_rd, rs, rt);
  assign br_mem   = id_valid & i_branch & i_mem_MemRead & src_hit(i_mem_rd, rs, rt);

  // Stall request: flush wins, HOLD always stalls, RUN stalls on any hazard
  always_comb begin
    o_stall = 1'b0;
    if (i_flush)                o_stall = 1'b0;
    else if (state == ST_HOLD)  o_stall = 1'b1;
    else                        o_stall = load_use | br_ex | br_mem;
  end

  assign bubble = i_flush | o_stall;

  // Branch operands: ALU result in MEM is forwarded, loads in MEM are not
  always_comb begin
    cmp_rs = rf_rs;
    cmp_rt = rf_rt;
    if (i_mem_RegWrite && !i_mem_MemRead && (i_mem_rd != '0)) begin
      if (i_mem_rd == rs) cmp_rs = i_mem_result;
      if (i_mem_rd == rt) cmp_rt = i_mem_result;
    end
  end

  assign o_branch_taken  = id_valid & ~o_stall & i_branch & ((cmp_rs == cmp_rt) ^ i_bneq);
  assign o_branch_target = i_PC + (imm << 2);

  // ID/EX register and stall FSM
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= ST_RUN;
      cnt        <= '0;
      o_valid    <= 1'b0;
      o_PC       <= '0;
      o_rs_data  <= '0;
      o_rt_data  <= '0;
      o_imm      <= '0;
      o_rs       <= '0;
      o_rt       <= '0;
      o_rd       <= '0;
      o_ctrl_exc <= NB_CTRL_EX'(BUBBLE_EX);
      o_ctrl_mem <= NB_CTRL_M'(BUBBLE_M);
      o_ctrl_wb  <= NB_CTRL_WB'(BUBBLE_WB);
    end else begin
      if (bubble) begin
        o_valid    <= 1'b0;
        o_ctrl_exc <= NB_CTRL_EX'(BUBBLE_EX);
        o_ctrl_mem <= NB_CTRL_M'(BUBBLE_M);
        o_ctrl_wb  <= NB_CTRL_WB'(BUBBLE_WB);
      end else begin
        o_valid    <= i_valid;
        o_PC       <= i_PC;
        o_rs_data  <= rf_rs;
        o_rt_data  <= rf_rt;
        o_imm      <= imm;
        o_rs       <= rs;
        o_rt       <= rt;
        o_rd       <= rd;
        o_ctrl_exc <= i_valid ? i_ctrl_exc : NB_CTRL_EX'(BUBBLE_EX);
        o_ctrl_mem <= i_valid ? i_ctrl_mem : NB_CTRL_M'(BUBBLE_M);
        o_ctrl_wb  <= i_valid ? i_ctrl_wb  : NB_CTRL_WB'(BUBBLE_WB);
      end

      if (i_flush) begin
        state <= ST_RUN;
        cnt   <= '0;
      end else if (state == ST_HOLD) begin
        cnt <= cnt - 2'd1;
        if (cnt == 2'd1) state <= ST_RUN;
      end else if (load_use) begin
        cnt   <= LU_CNT;
        state <= (LU_CNT != 2'd0) ? ST_HOLD : ST_RUN;
      end
    end
  end

endmodule

// File: tb/tb_seg_decode_hazard.sv
// tb/tb_seg_decode_hazard.sv - directed self-checking bench, LOAD_USE_STALL=1 and =3 instances side by side
module tb_seg_decode_hazard;

  localparam int LEN = 32;
  localparam int NA  = 5;
  localparam int NEX = 6;
  localparam int NM  = 9;
  localparam int NWB = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           valid;
  logic [LEN-1:0] pc, instr;
  logic [NEX-1:0] ctrl_exc;
  logic [NM-1:0]  ctrl_mem;
  logic [NWB-1:0] ctrl_wb;
  logic           branch, bneq, flush;
  logic [NA-1:0]  ex_rd, mem_rd, wb_rd;
  logic           ex_regwrite, ex_memread;
  logic           mem_regwrite, mem_memread;
  logic [LEN-1:0] mem_result, wb_data;
  logic           wb_regwrite;

  logic           stall_a, taken_a, valid_a;
  logic [LEN-1:0] target_a, pc_a, rs_data_a, rt_data_a, imm_a;
  logic [NA-1:0]  rs_a, rt_a, rd_a;
  logic [NEX-1:0] exc_a;
  logic [NM-1:0]  mem_a;
  logic [NWB-1:0] wb_a;

  logic           stall_b, taken_b, valid_b;
  logic [LEN-1:0] target_b, pc_b, rs_data_b, rt_data_b, imm_b;
  logic [NA-1:0]  rs_b, rt_b, rd_b;
  logic [NEX-1:0] exc_b;
  logic [NM-1:0]  mem_b;
  logic [NWB-1:0] wb_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  seg_decode_hazard #(.LOAD_USE_STALL(1)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_PC(pc), .i_instruction(instr),
    .i_ctrl_exc(ctrl_exc), .i_ctrl_mem(ctrl_mem), .i_ctrl_wb(ctrl_wb),
    .i_branch(branch), .i_bneq(bneq), .i_flush(flush),
    .i_ex_rd(ex_rd), .i_ex_RegWrite(ex_regwrite), .i_ex_MemRead(ex_memread),
    .i_mem_rd(mem_rd), .i_mem_RegWrite(mem_regwrite), .i_mem_MemRead(mem_memread),
    .i_mem_result(mem_result), .i_wb_rd(wb_rd), .i_wb_RegWrite(wb_regwrite), .i_wb_data(wb_data),
    .o_stall(stall_a), .o_branch_taken(taken_a), .o_branch_target(target_a),
    .o_valid(valid_a), .o_PC(pc_a), .o_rs_data(rs_data_a), .o_rt_data(rt_data_a), .o_imm(imm_a),
    .o_rs(rs_a), .o_rt(rt_a), .o_rd(rd_a),
    .o_ctrl_exc(exc_a), .o_ctrl_mem(mem_a), .o_ctrl_wb(wb_a)
  );

  seg_decode_hazard #(.LOAD_USE_STALL(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_PC(pc), .i_instruction(instr),
    .i_ctrl_exc(ctrl_exc), .i_ctrl_mem(ctrl_mem), .i_ctrl_wb(ctrl_wb),
    .i_branch(branch), .i_bneq(bneq), .i_flush(flush),
    .i_ex_rd(ex_rd), .i_ex_RegWrite(ex_regwrite), .i_ex_MemRead(ex_memread),
    .i_mem_rd(mem_rd), .i_mem_RegWrite(mem_regwrite), .i_mem_MemRead(mem_memread),
    .i_mem_result(mem_result), .i_wb_rd(wb_rd), .i_wb_RegWrite(wb_regwrite), .i_wb_data(wb_data),
    .o_stall(stall_b), .o_branch_taken(taken_b), .o_branch_target(target_b),
    .o_valid(valid_b), .o_PC(pc_b), .o_rs_data(rs_data_b), .o_rt_data(rt_data_b), .o_imm(imm_b),
    .o_rs(rs_b), .o_rt(rt_b), .o_rd(rd_b),
    .o_ctrl_exc(exc_b), .o_ctrl_mem(mem_b), .o_ctrl_wb(wb_b)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_add(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] i_fmt(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_pipe();
    ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = '0; mem_regwrite = 0; mem_memread = 0; mem_result = '0;
    wb_rd = '0; wb_regwrite = 0; wb_data = '0;
  endtask

  task automatic idle();
    valid = 0; pc = '0; instr = '0;
    ctrl_exc = '0; ctrl_mem = '0; ctrl_wb = '0;
    branch = 0; bneq = 0; flush = 0;
    clear_pipe();
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
    wb_rd = a; wb_data = d; wb_regwrite = 1;
    tick();
    wb_regwrite = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_stall_a, exp_stall_b, exp_valid_a, exp_valid_b;

    rst = 1;
    idle();
    #12;
    chk("rst_valid", valid_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_rs_data", rs_data_a, 0);
    chk("rst_exc_b", exc_b, 0);
    chk("rst_stall_b", stall_b, 0);
    chk("rst_taken", taken_a, 0);
    #1;
    rst = 0;
    tick();

    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);
    wb_write(5'd4, 32'd5);
    wb_write(5'd5, 32'd7);

    // plain ADD r3,r1,r5 through ID/EX
    valid = 1; instr = r_add(5'd1, 5'd5, 5'd3); pc = 32'h100;
    ctrl_exc = 6'h2a; ctrl_mem = 9'h000; ctrl_wb = 2'b11;
    settle();
    chk("add_stall", stall_a, 0);
    tick();
    chk("add_valid", valid_a, 1);
    chk("add_pc", pc_a, 32'h100);
    chk("add_rs_data", rs_data_a, 32'h11);
    chk("add_rt_data", rt_data_a, 32'd7);
    chk("add_rs", rs_a, 1);
    chk("add_rt", rt_a, 5);
    chk("add_rd", rd_a, 3);
    chk("add_imm", imm_a, 32'h1820);
    chk("add_exc", exc_a, 6'h2a);
    chk("add_wb", wb_a, 2'b11);

    // load-use: LW r2 in EX, ADD r3,r2,r1 in ID
    instr = r_add(5'd2, 5'd1, 5'd3); pc = 32'h104;
    ex_rd = 5'd2; ex_regwrite = 1; ex_memread = 1;
    exp_stall_a = 4'b0001; exp_stall_b = 4'b0111;
    exp_valid_a = 4'b1110; exp_valid_b = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
      end
      settle();
      chk($sformatf("lu_stall_a_c%0d", c), stall_a, exp_stall_a[c]);
      chk($sformatf("lu_stall_b_c%0d", c), stall_b, exp_stall_b[c]);
      tick();
      chk($sformatf("lu_valid_a_c%0d", c), valid_a, exp_valid_a[c]);
      chk($sformatf("lu_valid_b_c%0d", c), valid_b, exp_valid_b[c]);
      if (c == 0) begin
        chk("lu_bubble_exc_b", exc_b, 0);
        chk("lu_bubble_keeps_data_a", rs_data_a, 32'h11);
      end
    end
    chk("lu_rd_b", rd_b, 3);
    chk("lu_rs_data_b", rs_data_b, 32'h22);
    chk("lu_exc_b", exc_b, 6'h2a);

    // ID branch with MEM forwarding, imm = -1
    idle();
    valid = 1; branch = 1; pc = 32'h204; instr = i_fmt(6'h04, 5'd4, 5'd5, 16'hFFFF);
    mem_rd = 5'd4; mem_regwrite = 1; mem_result = 32'd7;
    settle();
    chk("brf_stall", stall_a, 0);
    chk("brf_taken", taken_a, 1);
    chk("brf_target", target_a, 32'h200);
    bneq = 1; settle();
    chk("brf_bne_taken", taken_a, 0);
    mem_regwrite = 0; settle();
    chk("brnf_bne_taken", taken_a, 1);
    bneq = 0; settle();
    chk("brnf_beq_taken", taken_a, 0);
    mem_regwrite = 1; mem_memread = 1; settle();
    chk("brml_stall", stall_a, 1);
    chk("brml_taken", taken_a, 0);
    clear_pipe();
    instr = i_fmt(6'h04, 5'd4, 5'd5, 16'h0010); settle();
    chk("br_target_pos", target_a, 32'h244);
    chk("br_nf_taken", taken_a, 0);

    // branch with ALU producer in EX: one stall cycle
    ex_rd = 5'd5; ex_regwrite = 1; settle();
    chk("brex_stall_a", stall_a, 1);
    chk("brex_stall_b", stall_b, 1);
    chk("brex_taken", taken_a, 0);
    tick();
    chk("brex_bubble", valid_a, 0);
    clear_pipe();
    mem_rd = 5'd5; mem_regwrite = 1; mem_result = 32'd5; settle();
    chk("brex_release_stall", stall_a, 0);
    chk("brex_release_taken", taken_a, 1);
    tick();
    chk("brex_advance", valid_a, 1);

    // branch with load in EX: two stall cycles on the LOAD_USE_STALL=1 instance
    clear_pipe();
    ex_rd = 5'd5; ex_regwrite = 1; ex_memread = 1; settle();
    chk("brld_stall_c0", stall_a, 1);
    tick();
    clear_pipe();
    mem_rd = 5'd5; mem_regwrite = 1; mem_memread = 1; mem_result = 32'hBAD; settle();
    chk("brld_stall_c1", stall_a, 1);
    chk("brld_taken_c1", taken_a, 0);
    tick();
    clear_pipe();
    wb_rd = 5'd5; wb_regwrite = 1; wb_data = 32'd5; settle();
    chk("brld_stall_c2", stall_a, 0);
    chk("brld_taken_c2", taken_a, 1);
    tick();
    idle();
    tick();

    // write-first bypass, and r0 stays zero
    valid = 1; instr = r_add(5'd9, 5'd0, 5'd10); pc = 32'h300;
    wb_rd = 5'd9; wb_data = 32'hDEADBEEF; wb_regwrite = 1;
    tick();
    chk("byp_rs_data", rs_data_a, 32'hDEADBEEF);
    chk("byp_rt_r0", rt_data_a, 0);
    instr = r_add(5'd0, 5'd9, 5'd11);
    wb_rd = 5'd0; wb_data = 32'h1234;
    tick();
    wb_regwrite = 0;
    chk("r0_write_rs", rs_data_a, 0);
    chk("r9_stored_rt", rt_data_a, 32'hDEADBEEF);

    // flush in the second stall cycle of a 3-cycle load-use
    instr = r_add(5'd2, 5'd1, 5'd3); pc = 32'h400; ctrl_exc = 6'h2a;
    ex_rd = 5'd2; ex_regwrite = 1; ex_memread = 1; settle();
    chk("fl_stall_c0", stall_b, 1);
    tick();
    clear_pipe(); settle();
    chk("fl_hold_stall", stall_b, 1);
    flush = 1; settle();
    chk("fl_stall_deassert", stall_b, 0);
    chk("fl_taken", taken_b, 0);
    tick();
    chk("fl_bubble_valid", valid_b, 0);
    chk("fl_bubble_exc", exc_b, 0);
    flush = 0; settle();
    chk("fl_run_stall", stall_b, 0);
    tick();
    chk("fl_advance_valid", valid_b, 1);
    chk("fl_advance_pc", pc_b, 32'h400);

    // asynchronous reset during HOLD
    ex_rd = 5'd2; ex_regwrite = 1; ex_memread = 1;
    tick();
    clear_pipe(); settle();
    chk("ar_hold_stall", stall_b, 1);
    chk("ar_pre_pc", pc_b, 32'h400);
    #2;
    rst = 1;
    #1;
    chk("ar_pc_b", pc_b, 0);
    chk("ar_rs_data_b", rs_data_b, 0);
    chk("ar_pc_a", pc_a, 0);
    chk("ar_stall_b", stall_b, 0);
    #1;
    rst = 0;
    settle();
    chk("ar_post_stall", stall_b, 0);
    tick();
    chk("ar_post_valid", valid_b, 1);
    chk("ar_regs_cleared", rs_data_b, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
